alu_issue: RTL and testbench

- Issue/writeback stage directly upstream of the RV32I ALU. Accepts one 32-bit OP or OP-IMM instruction at a time over a valid/ready handshake.
- Reads operands from an internal 32x32 register file and drives the ALU's enable/funct7/operand inputs.
- Waits a fixed ALU latency, then captures the ALU destination and writes it back to rd.
- Strictly one instruction in flight, so no forwarding or hazard logic is needed.

---
 rtl/alu_issue.sv | 161 ++++++++++++++++
 tb/tb_alu_issue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// RV32I issue/writeback stage feeding a fixed-latency ALU.
// Holds the architectural register file and allows one instruction in flight.
module alu_issue #(
  parameter int XLEN        = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            alu_enable,
  output logic [6:0]      alu_funct7,
  output logic [2:0]      alu_funct3,
  output logic [XLEN-1:0] alu_operand_0,
  output logic [XLEN-1:0] alu_operand_1,
  input  logic [XLEN-1:0] alu_destination,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(ALU_LATENCY - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] op0_q, op0_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [6:0]      f7_q, f7_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wbd_q, wbd_d;
  logic            ill_q, ill_d;
  logic            we;
  logic [XLEN-1:0] rf_q [32];

  logic [4:0]      rs1, rs2;
  logic [2:0]      f3;
  logic            is_op, is_opi, is_shift;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_s, imm_sh;

  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign f3       = instr[14:12];
  assign is_op    = instr[6:0] == 7'b0110011;
  assign is_opi   = instr[6:0] == 7'b0010011;
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign imm_s    = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_sh   = XLEN'(instr[24:20]);
  // x0 is never written, but the mux keeps reads hard-wired to zero
  assign rs1_val  = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : rf_q[rs2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    f7_d    = f7_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    wbd_d   = wbd_q;
    ill_d   = 1'b0;
    we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          unique case (1'b1)
            is_op: begin
              op0_d   = rs1_val;
              op1_d   = rs2_val;
              f7_d    = instr[31:25];
              f3_d    = f3;
              rd_d    = instr[11:7];
              state_d = S_ISSUE;
            end
            is_opi: begin
              op0_d   = rs1_val;
              op1_d   = is_shift ? imm_sh : imm_s;
              f7_d    = is_shift ? instr[31:25] : 7'd0;
              f3_d    = f3;
              rd_d    = instr[11:7];
              state_d = S_ISSUE;
            end
            default: ill_d = 1'b1;
          endcase
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          wbd_d   = alu_destination;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WB: begin
        we      = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op0_q   <= '0;
      op1_q   <= '0;
      f7_q    <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      wbd_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      f7_q    <= f7_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      wbd_q   <= wbd_d;
      ill_q   <= ill_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (we && rd_q != 5'd0) begin
      rf_q[rd_q] <= wbd_q;
    end
  end

  assign instr_ready   = state_q == S_IDLE;
  assign alu_enable    = state_q == S_ISSUE;
  assign wb_valid      = state_q == S_WB;
  assign alu_funct7    = f7_q;
  assign alu_funct3    = f3_q;
  assign alu_operand_0 = op0_q;
  assign alu_operand_1 = op1_q;
  assign wb_rd         = rd_q;
  assign wb_data       = wbd_q;
  assign illegal       = ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a one-cycle ALU model.
// Each scenario task drives its vectors and checks inline.
module tb_alu_issue;

  logic        clock;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        alu_enable;
  logic [6:0]  alu_funct7;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_operand_0;
  logic [31:0] alu_operand_1;
  logic [31:0] alu_destination;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int en_cnt = 0;
  int wb_cnt = 0;
  int il_cnt = 0;

  int          hs_cyc, wb_cyc;
  int          c_en_n, c_wb_n;
  logic        c_rdy0, c_rdy1, c_en, c_en1, c_wbv;
  logic [31:0] c_op0, c_op1, c_wbd;
  logic [6:0]  c_f7;
  logic [2:0]  c_f3;
  logic [4:0]  c_rd;

  alu_issue #(.XLEN(32), .ALU_LATENCY(1)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_ready     (instr_ready),
    .alu_enable      (alu_enable),
    .alu_funct7      (alu_funct7),
    .alu_funct3      (alu_funct3),
    .alu_operand_0   (alu_operand_0),
    .alu_operand_1   (alu_operand_1),
    .alu_destination (alu_destination),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .illegal         (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] alu_f(
    input logic [6:0] f7, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return f7[5] ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (alu_enable)
      alu_destination <= alu_f(alu_funct7, alu_funct3, alu_operand_0, alu_operand_1);
  end

  always @(negedge clock) begin
    if (alu_enable) en_cnt++;
    if (wb_valid)   wb_cnt++;
    if (illegal)    il_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one instruction to completion and records what was observed.
  task automatic exec(input logic [31:0] w);
    int n;
    int en0, wb0;
    n = 0;
    instr_valid = 1'b1;
    instr = w;
    while (!instr_ready && n < 20) begin step(); n++; end
    hs_cyc = cyc;
    en0 = en_cnt;
    wb0 = wb_cnt;
    step();
    instr_valid = 1'b0;
    instr = '0;
    c_rdy0 = instr_ready;
    c_en   = alu_enable;
    c_op0  = alu_operand_0;
    c_op1  = alu_operand_1;
    c_f7   = alu_funct7;
    c_f3   = alu_funct3;
    step();
    c_en1 = alu_enable;
    n = 0;
    while (!wb_valid && n < 20) begin step(); n++; end
    c_wbv  = wb_valid;
    wb_cyc = cyc;
    c_rd   = wb_rd;
    c_wbd  = wb_data;
    step();
    c_rdy1 = instr_ready;
    c_en_n = en_cnt - en0;
    c_wb_n = wb_cnt - wb0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    instr_valid = 1'b1;
    instr = 32'h00500093;
    alu_destination = '0;
    repeat (3) step();
    checks++;
    if (instr_ready !== 1'b1) begin errors++;
      $display("FAIL rst_ready got=%b exp=1", instr_ready); end
    checks++;
    if (alu_enable !== 1'b0 || wb_valid !== 1'b0 || illegal !== 1'b0) begin errors++;
      $display("FAIL rst_strobes got en=%b wb=%b il=%b exp=0", alu_enable, wb_valid, illegal); end
    checks++;
    if (alu_operand_0 !== 32'd0 || alu_operand_1 !== 32'd0 || wb_data !== 32'd0) begin errors++;
      $display("FAIL rst_data got op0=%h op1=%h wbd=%h exp=0", alu_operand_0, alu_operand_1, wb_data); end
    checks++;
    if (en_cnt !== 0) begin errors++;
      $display("FAIL rst_no_accept got en_cnt=%0d exp=0", en_cnt); end
    instr_valid = 1'b0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_addi();
    exec(32'h00500093);
    checks++;
    if (c_en !== 1'b1 || c_en1 !== 1'b0 || c_en_n !== 1) begin errors++;
      $display("FAIL addi_enable got en=%b next=%b count=%0d exp 1,0,1", c_en, c_en1, c_en_n); end
    checks++;
    if (c_op0 !== 32'd0 || c_op1 !== 32'd5 || c_f7 !== 7'd0) begin errors++;
      $display("FAIL addi_ops got op0=%h op1=%h f7=%h exp 0,5,0", c_op0, c_op1, c_f7); end
    checks++;
    if (c_wbv !== 1'b1 || wb_cyc - hs_cyc !== 3) begin errors++;
      $display("FAIL addi_wb_time got wbv=%b delay=%0d exp 1,3", c_wbv, wb_cyc - hs_cyc); end
    checks++;
    if (c_rd !== 5'd1 || c_wbd !== 32'd5 || c_wb_n !== 1) begin errors++;
      $display("FAIL addi_wb got rd=%0d data=%h n=%0d exp 1,5,1", c_rd, c_wbd, c_wb_n); end
    checks++;
    if (c_rdy0 !== 1'b0 || c_rdy1 !== 1'b1) begin errors++;
      $display("FAIL addi_ready got busy=%b after=%b exp 0,1", c_rdy0, c_rdy1); end
  endtask

  task automatic test_back_to_back();
    int h1;
    exec(32'h00108133);
    h1 = hs_cyc;
    checks++;
    if (c_op0 !== 32'd5 || c_op1 !== 32'd5 || c_f7 !== 7'h00) begin errors++;
      $display("FAIL add_ops got op0=%h op1=%h f7=%h exp 5,5,00", c_op0, c_op1, c_f7); end
    exec(32'h401101B3);
    checks++;
    if (c_op0 !== 32'd10 || c_op1 !== 32'd5 || c_f7 !== 7'h20) begin errors++;
      $display("FAIL sub_ops got op0=%h op1=%h f7=%h exp a,5,20", c_op0, c_op1, c_f7); end
    checks++;
    if (hs_cyc - h1 !== 4) begin errors++;
      $display("FAIL b2b_spacing got=%0d exp=4", hs_cyc - h1); end
    checks++;
    if (c_rd !== 5'd3 || c_wbd !== 32'd5) begin errors++;
      $display("FAIL sub_wb got rd=%0d data=%h exp 3,5", c_rd, c_wbd); end
  endtask

  task automatic test_shift_imm();
    exec(32'hFFF00213);
    checks++;
    if (c_op1 !== 32'hFFFFFFFF || c_f7 !== 7'd0) begin errors++;
      $display("FAIL addi_neg got op1=%h f7=%h exp ffffffff,0", c_op1, c_f7); end
    exec(32'h40325293);
    checks++;
    if (c_op0 !== 32'hFFFFFFFF || c_op1 !== 32'd3) begin errors++;
      $display("FAIL srai_ops got op0=%h op1=%h exp ffffffff,3", c_op0, c_op1); end
    checks++;
    if (c_f7 !== 7'h20 || c_f3 !== 3'd5) begin errors++;
      $display("FAIL srai_funct got f7=%h f3=%0d exp 20,5", c_f7, c_f3); end
    checks++;
    if (c_rd !== 5'd5 || c_wbd !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL srai_wb got rd=%0d data=%h exp 5,ffffffff", c_rd, c_wbd); end
  endtask

  task automatic test_x0();
    exec(32'h00700013);
    checks++;
    if (c_wbv !== 1'b1 || c_rd !== 5'd0 || c_wb_n !== 1) begin errors++;
      $display("FAIL x0_wb got wbv=%b rd=%0d n=%0d exp 1,0,1", c_wbv, c_rd, c_wb_n); end
    exec(32'h00000333);
    checks++;
    if (c_op0 !== 32'd0 || c_op1 !== 32'd0) begin errors++;
      $display("FAIL x0_read got op0=%h op1=%h exp 0,0", c_op0, c_op1); end
  endtask

  task automatic test_illegal();
    int en0, il0;
    en0 = en_cnt;
    il0 = il_cnt;
    instr_valid = 1'b1;
    instr = 32'h00000073;
    step();
    instr_valid = 1'b0;
    instr = '0;
    checks++;
    if (illegal !== 1'b1 || instr_ready !== 1'b1) begin errors++;
      $display("FAIL ecall_pulse got il=%b ready=%b exp 1,1", illegal, instr_ready); end
    repeat (3) step();
    checks++;
    if (il_cnt - il0 !== 1 || en_cnt - en0 !== 0) begin errors++;
      $display("FAIL ecall_count got il=%0d en=%0d exp 1,0", il_cnt - il0, en_cnt - en0); end
    checks++;
    if (instr_ready !== 1'b1 || illegal !== 1'b0) begin errors++;
      $display("FAIL ecall_after got ready=%b il=%b exp 1,0", instr_ready, illegal); end
  endtask

  task automatic test_reset_abort();
    int wb0;
    wb0 = wb_cnt;
    instr_valid = 1'b1;
    instr = 32'h00900393;
    step();
    instr_valid = 1'b0;
    instr = '0;
    step();
    reset_n = 1'b0;
    #2;
    checks++;
    if (instr_ready !== 1'b1 || alu_enable !== 1'b0 || wb_valid !== 1'b0) begin errors++;
      $display("FAIL abort_reset got ready=%b en=%b wb=%b exp 1,0,0", instr_ready, alu_enable, wb_valid); end
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    checks++;
    if (wb_cnt - wb0 !== 0) begin errors++;
      $display("FAIL abort_no_wb got=%0d exp=0", wb_cnt - wb0); end
    exec(32'h00738433);
    checks++;
    if (c_op0 !== 32'd0 || c_op1 !== 32'd0) begin errors++;
      $display("FAIL abort_x7 got op0=%h op1=%h exp 0,0", c_op0, c_op1); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_shift_imm();
    test_x0();
    test_illegal();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
